// File: rtl/sm4_key_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sm4_pkg                                                              |
// | Shared SM4 key-schedule constants, helpers, index and state types.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sm4_pkg;

    localparam logic [31:0] FK0 = 32'hA3B1BAC6;
    localparam logic [31:0] FK1 = 32'h56AA3350;
    localparam logic [31:0] FK2 = 32'h677D9197;
    localparam logic [31:0] FK3 = 32'hB27022DC;

    typedef logic [4:0] round_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RND_A = 2'd1,
        RND_B = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [31:0] rot32(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] l_key(input logic [31:0] t);
        return t ^ rot32(t, 13) ^ rot32(t, 23);
    endfunction

    // Byte j (MSB first) = (4i+j)*7, wrapping at 8 bits.
    function automatic logic [31:0] ck_word(input round_idx_t i);
        logic [31:0] ck;
        logic [7:0]  b;
        ck = '0;
        for (int j = 0; j < 4; j++) begin
            b = ({1'b0, i, 2'b00} + j[7:0]) * 8'd7;
            ck[31-8*j -: 8] = b;
        end
        return ck;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sm4_key_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sm4_key_sched_if                                                     |
// | Control, read and stream port bundle of the SM4 key scheduler.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface sm4_key_sched_if import sm4_pkg::*;;
    logic         key_start;
    logic [127:0] mk;
    logic         dec_mode;
    round_idx_t   rk_addr;
    logic [31:0]  rk;
    logic         rk_valid;
    round_idx_t   rk_idx;
    logic [31:0]  rk_stream;
    logic         busy;
    logic         key_ready;

    modport master (
        output key_start, mk, dec_mode, rk_addr,
        input  rk, rk_valid, rk_idx, rk_stream, busy, key_ready
    );

    modport slave (
        input  key_start, mk, dec_mode, rk_addr,
        output rk, rk_valid, rk_idx, rk_stream, busy, key_ready
    );
endinterface
`default_nettype wire

// File: rtl/sm4_key_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sm4_key_regfile                                                      |
// | 32x32 round-key store: one write port, async mirrored read port.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sm4_key_regfile import sm4_pkg::*; (
    input  wire logic        clk,
    input  wire logic        we,
    input  wire round_idx_t  waddr,
    input  wire logic [31:0] wdata,
    input  wire logic        dec_mode,
    input  wire round_idx_t  raddr,
    output logic      [31:0] rdata
);
    logic [31:0] mem [32];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // For a 5-bit index, ~raddr == 31 - raddr (decrypt order).
    assign rdata = mem[dec_mode ? ~raddr : raddr];
endmodule
`default_nettype wire

// File: rtl/sm4_sbox.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sm4_sbox                                                             |
// | SM4 byte substitution with registered output, no reset.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sm4_sbox (
    input  wire logic       clk,
    input  wire logic [7:0] din,
    output logic      [7:0] dout
);
    // Entry 0 occupies the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    always_ff @(posedge clk) begin
        dout <= SBOX_TABLE[2047 - 8*int'(din) -: 8];
    end
endmodule
`default_nettype wire

// File: rtl/sm4_key_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sm4_key_sched                                                        |
// | SM4 key expansion: one round key per two cycles, stored and streamed.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sm4_key_sched import sm4_pkg::*; #(
    parameter int ROUNDS = 32
) (
    input  wire logic      clk,
    input  wire logic      rst,
    sm4_key_sched_if.slave bus
);
    state_t      state;
    state_t      state_nx;
    round_idx_t  ctr;
    logic        key_ready;
    logic [31:0] k0, k1, k2, k3;
    logic [31:0] sbox_in;
    logic [31:0] sbox_out;
    logic [31:0] rk_word;
    logic [31:0] rf_rdata;
    logic        busy;
    logic        start_acc;
    logic        last;
    logic        rk_valid;

    assign busy      = (state == RND_A) || (state == RND_B);
    assign start_acc = bus.key_start && !busy;
    assign last      = (ctr == round_idx_t'(ROUNDS - 1));
    assign rk_valid  = (state == RND_B);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (bus.key_start) state_nx = RND_A;
            RND_A:      state_nx = RND_B;
            RND_B:      state_nx = last ? DONE : RND_A;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr       <= '0;
            key_ready <= 1'b0;
            k0        <= '0;
            k1        <= '0;
            k2        <= '0;
            k3        <= '0;
        end else if (start_acc) begin
            ctr       <= '0;
            key_ready <= 1'b0;
            k0        <= bus.mk[127:96] ^ FK0;
            k1        <= bus.mk[95:64]  ^ FK1;
            k2        <= bus.mk[63:32]  ^ FK2;
            k3        <= bus.mk[31:0]   ^ FK3;
        end else if (state == RND_B) begin
            {k0, k1, k2, k3} <= {k1, k2, k3, rk_word};
            if (last) begin
                key_ready <= 1'b1;
            end else begin
                ctr <= ctr + round_idx_t'(1);
            end
        end
    end

    // S-box inputs settle in RND_A and are captured at its closing edge.
    assign sbox_in = k1 ^ k2 ^ k3 ^ ck_word(ctr);

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        sm4_sbox u_sbox (
            .clk  (clk),
            .din  (sbox_in[8*b +: 8]),
            .dout (sbox_out[8*b +: 8])
        );
    end

    assign rk_word = k0 ^ l_key(sbox_out);

    sm4_key_regfile u_regfile (
        .clk      (clk),
        .we       (rk_valid),
        .waddr    (ctr),
        .wdata    (rk_word),
        .dec_mode (bus.dec_mode),
        .raddr    (bus.rk_addr),
        .rdata    (rf_rdata)
    );

    assign bus.busy      = busy;
    assign bus.key_ready = key_ready;
    assign bus.rk_valid  = rk_valid;
    assign bus.rk_idx    = rk_valid ? ctr : '0;
    assign bus.rk_stream = rk_valid ? rk_word : '0;
    assign bus.rk        = key_ready ? rf_rdata : '0;
endmodule
`default_nettype wire

// File: tb/tb_sm4_key_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sm4_key_sched                                                     |
// | Directed self-checking bench for the SM4 key scheduler.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sm4_key_sched;
    localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [2047:0] TB_SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    logic clk;
    logic rst;
    sm4_key_sched_if bus ();

    sm4_key_sched #(.ROUNDS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_k  [36];
    logic [31:0] exp_rk [32];
    logic [4:0]  s_idx  [40];
    logic [31:0] s_val  [40];
    int          s_cyc  [40];
    int          s_n;
    int          ready_cyc;
    int          rk_nz;

    function automatic logic [31:0] tb_rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] tb_tau(input logic [31:0] w);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) begin
            r[8*j +: 8] = TB_SBOX[2047 - 8*int'(w[8*j +: 8]) -: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] tb_lkey(input logic [31:0] t);
        return t ^ tb_rol(t, 13) ^ tb_rol(t, 23);
    endfunction

    function automatic logic [31:0] tb_ck(input int i);
        logic [31:0] c;
        for (int j = 0; j < 4; j++) begin
            c[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
        end
        return c;
    endfunction

    task automatic model(input logic [127:0] key);
        exp_k[0] = key[127:96] ^ 32'hA3B1BAC6;
        exp_k[1] = key[95:64]  ^ 32'h56AA3350;
        exp_k[2] = key[63:32]  ^ 32'h677D9197;
        exp_k[3] = key[31:0]   ^ 32'hB27022DC;
        for (int i = 0; i < 32; i++) begin
            exp_k[i+4] = exp_k[i] ^ tb_lkey(tb_tau(exp_k[i+1] ^ exp_k[i+2] ^ exp_k[i+3] ^ tb_ck(i)));
            exp_rk[i]  = exp_k[i+4];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [127:0] key);
        bus.mk        = key;
        bus.key_start = 1'b1;
        tick();
        bus.key_start = 1'b0;
        bus.mk        = ~key;
    endtask

    // Runs 70 cycles after the start edge, recording stream strobes and KEY_READY timing.
    task automatic collect(input int kick_at);
        s_n = 0; ready_cyc = -1; rk_nz = 0;
        for (int i = 0; i < 40; i++) s_val[i] = 'x;
        for (int c = 1; c <= 70; c++) begin
            bus.rk_addr  = 5'(c);
            bus.dec_mode = c[0];
            if (c == kick_at) begin
                bus.key_start = 1'b1;
                bus.mk        = 128'hDEADBEEF_CAFEF00D_01020304_A5A5A5A5;
            end
            tick();
            bus.key_start = 1'b0;
            if (bus.rk_valid === 1'b1 && s_n < 40) begin
                s_idx[s_n] = bus.rk_idx;
                s_val[s_n] = bus.rk_stream;
                s_cyc[s_n] = c;
                s_n++;
            end
            if (bus.key_ready !== 1'b1 && bus.rk !== 32'h0) rk_nz++;
            if (bus.key_ready === 1'b1 && ready_cyc < 0) ready_cyc = c;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.key_start = 1'b0; bus.mk = '0; bus.dec_mode = 1'b0; bus.rk_addr = 5'd3;
        tick(); tick();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.key_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", bus.key_ready); end
        checks++; if (bus.rk_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", bus.rk_valid); end
        checks++; if (bus.rk_idx !== 5'd0) begin failures++; $display("FAIL reset_idx got=%0d want=0", bus.rk_idx); end
        checks++; if (bus.rk_stream !== 32'h0) begin failures++; $display("FAIL reset_stream got=%h want=0", bus.rk_stream); end
        checks++; if (bus.rk !== 32'h0) begin failures++; $display("FAIL reset_rk got=%h want=0", bus.rk); end
        rst = 1'b0;
        tick();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_standard();
        model(STD_KEY);
        do_start(STD_KEY);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL std_busy got=%b want=1", bus.busy); end
        collect(0);
        checks++; if (s_n !== 32) begin failures++; $display("FAIL std_count got=%0d want=32", s_n); end
        for (int i = 0; i < 32; i++) begin
            checks++; if (s_idx[i] !== 5'(i) || s_cyc[i] !== 2*i+1 || s_val[i] !== exp_rk[i]) begin
                failures++; $display("FAIL std_stream[%0d] got=idx%0d/cyc%0d/%h want=idx%0d/cyc%0d/%h", i, s_idx[i], s_cyc[i], s_val[i], i, 2*i+1, exp_rk[i]);
            end
        end
        checks++; if (ready_cyc !== 64) begin failures++; $display("FAIL std_ready_cycle got=%0d want=64", ready_cyc); end
        checks++; if (rk_nz !== 0) begin failures++; $display("FAIL std_rk_gated got=%0d want=0", rk_nz); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL std_done_busy got=%b want=0", bus.busy); end
        bus.dec_mode = 1'b0; bus.rk_addr = 5'd0; #1;
        checks++; if (bus.rk !== 32'hF12186F9) begin failures++; $display("FAIL std_rk0 got=%h want=F12186F9", bus.rk); end
        bus.rk_addr = 5'd1; #1;
        checks++; if (bus.rk !== 32'h41662B61) begin failures++; $display("FAIL std_rk1 got=%h want=41662B61", bus.rk); end
        bus.rk_addr = 5'd31; #1;
        checks++; if (bus.rk !== 32'h9124A012) begin failures++; $display("FAIL std_rk31 got=%h want=9124A012", bus.rk); end
        bus.dec_mode = 1'b1; bus.rk_addr = 5'd0; #1;
        checks++; if (bus.rk !== 32'h9124A012) begin failures++; $display("FAIL std_dec_rk0 got=%h want=9124A012", bus.rk); end
        for (int a = 0; a < 32; a++) begin
            for (int d = 0; d < 2; d++) begin
                bus.rk_addr = 5'(a); bus.dec_mode = d[0]; #1;
                checks++; if (bus.rk !== exp_rk[d ? 31-a : a]) begin
                    failures++; $display("FAIL std_sweep a=%0d dec=%0d got=%h want=%h", a, d, bus.rk, exp_rk[d ? 31-a : a]);
                end
            end
        end
    endtask

    task automatic test_ck();
        logic [31:0] e;
        model(STD_KEY);
        do_start(STD_KEY);
        collect(0);
        e = exp_k[0] ^ tb_lkey(tb_tau(exp_k[1] ^ exp_k[2] ^ exp_k[3] ^ 32'h00070E15));
        checks++; if (s_val[0] !== e) begin failures++; $display("FAIL ck_round0 got=%h want=%h", s_val[0], e); end
        e = exp_k[1] ^ tb_lkey(tb_tau(exp_k[2] ^ exp_k[3] ^ exp_k[4] ^ 32'h1C232A31));
        checks++; if (s_val[1] !== e) begin failures++; $display("FAIL ck_round1 got=%h want=%h", s_val[1], e); end
        e = exp_k[31] ^ tb_lkey(tb_tau(exp_k[32] ^ exp_k[33] ^ exp_k[34] ^ 32'h646B7279));
        checks++; if (s_val[31] !== e) begin failures++; $display("FAIL ck_round31 got=%h want=%h", s_val[31], e); end
    endtask

    task automatic test_ignore_busy();
        model(STD_KEY);
        do_start(STD_KEY);
        collect(10);
        checks++; if (s_n !== 32) begin failures++; $display("FAIL ign_count got=%0d want=32", s_n); end
        for (int i = 0; i < 32; i++) begin
            checks++; if (s_idx[i] !== 5'(i) || s_cyc[i] !== 2*i+1 || s_val[i] !== exp_rk[i]) begin
                failures++; $display("FAIL ign_stream[%0d] got=idx%0d/cyc%0d/%h want=idx%0d/cyc%0d/%h", i, s_idx[i], s_cyc[i], s_val[i], i, 2*i+1, exp_rk[i]);
            end
        end
        checks++; if (ready_cyc !== 64) begin failures++; $display("FAIL ign_ready_cycle got=%0d want=64", ready_cyc); end
        bus.dec_mode = 1'b0; bus.rk_addr = 5'd31; #1;
        checks++; if (bus.rk !== 32'h9124A012) begin failures++; $display("FAIL ign_rk31 got=%h want=9124A012", bus.rk); end
    endtask

    task automatic test_reset_mid();
        model(STD_KEY);
        do_start(STD_KEY);
        for (int c = 1; c <= 31; c++) tick();
        checks++; if (bus.rk_valid !== 1'b1 || bus.rk_idx !== 5'd15) begin
            failures++; $display("FAIL mid_round15 got=%b/%0d want=1/15", bus.rk_valid, bus.rk_idx);
        end
        rst = 1'b1; bus.rk_addr = 5'd0; bus.dec_mode = 1'b0; #1;
        checks++; if (bus.key_ready !== 1'b0) begin failures++; $display("FAIL mid_ready got=%b want=0", bus.key_ready); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b want=0", bus.busy); end
        checks++; if (bus.rk !== 32'h0) begin failures++; $display("FAIL mid_rk got=%h want=0", bus.rk); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.rk_valid !== 1'b0) begin
            failures++; $display("FAIL mid_idle got=%b/%b want=0/0", bus.busy, bus.rk_valid);
        end
        do_start(STD_KEY);
        collect(0);
        checks++; if (s_n !== 32 || ready_cyc !== 64) begin failures++; $display("FAIL mid_restart got=%0d/%0d want=32/64", s_n, ready_cyc); end
        for (int a = 0; a < 32; a++) begin
            bus.rk_addr = 5'(a); bus.dec_mode = 1'b0; #1;
            checks++; if (bus.rk !== exp_rk[a]) begin failures++; $display("FAIL mid_sweep a=%0d got=%h want=%h", a, bus.rk, exp_rk[a]); end
        end
    endtask

    task automatic test_back_to_back();
        model(128'h0);
        do_start(128'h0);
        checks++; if (bus.key_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_drop got=%b want=0", bus.key_ready); end
        checks++; if (bus.rk !== 32'h0) begin failures++; $display("FAIL b2b_rk_drop got=%h want=0", bus.rk); end
        collect(0);
        checks++; if (ready_cyc !== 64) begin failures++; $display("FAIL b2b_ready_cycle got=%0d want=64", ready_cyc); end
        checks++; if (rk_nz !== 0) begin failures++; $display("FAIL b2b_rk_gated got=%0d want=0", rk_nz); end
        for (int a = 0; a < 32; a++) begin
            for (int d = 0; d < 2; d++) begin
                bus.rk_addr = 5'(a); bus.dec_mode = d[0]; #1;
                checks++; if (bus.rk !== exp_rk[d ? 31-a : a]) begin
                    failures++; $display("FAIL b2b_sweep a=%0d dec=%0d got=%h want=%h", a, d, bus.rk, exp_rk[d ? 31-a : a]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_standard();
        test_ck();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
